// File: rtl/julia_dispatch.sv
// +--------------------------------------------------------------------------+
// | julia_dispatch : Julia renderer frame scheduler. Issues pixel coordinates |
// | to idle cores round-robin and merges finished results into one stream.   |
// | Optional: JULIA_PERF_CNT_EN adds frame_cycles (CLEAR..DONE cycle count). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module julia_dispatch #(
   parameter int NUM_CORES = 4,
   parameter int X_BITS    = 10,
   parameter int Y_BITS    = 9,
   parameter int ITER_BITS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           pix_clear,
   output logic                           pix_step,
   input  logic [X_BITS-1:0]              pix_x,
   input  logic [Y_BITS-1:0]              pix_y,
   input  logic                           pix_last,
   output logic [NUM_CORES-1:0]           core_start,
   output logic [X_BITS-1:0]              core_x,
   output logic [Y_BITS-1:0]              core_y,
   input  logic [NUM_CORES-1:0]           core_done,
   input  logic [NUM_CORES*ITER_BITS-1:0] core_iter,
   output logic [NUM_CORES-1:0]           core_ack,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [X_BITS-1:0]              res_x,
   output logic [Y_BITS-1:0]              res_y,
   output logic [ITER_BITS-1:0]           res_iter,
   output logic                           busy,
`ifdef JULIA_PERF_CNT_EN
   output logic [31:0]                    frame_cycles,
`endif
   output logic                           frame_done
);

   localparam int PTR_W = $clog2(NUM_CORES);
   localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CORES) s = s - NUM_CORES;
      return s[PTR_W-1:0];
   endfunction

   // Returns {found, index} of the first requester at or after ptr.
   function automatic logic [PTR_W:0] f_pick(input logic [NUM_CORES-1:0] req,
                                             input logic [PTR_W-1:0]     ptr);
      logic [PTR_W:0]   r;
      logic [PTR_W-1:0] idx;
      r = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = f_wrap(ptr, k);
         if (req[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   logic [2:0]           r_state;
   logic [2:0]           w_next;
   logic [NUM_CORES-1:0] r_busy;
   logic [PTR_W-1:0]     r_iptr;
   logic [PTR_W-1:0]     r_cptr;
   logic [X_BITS-1:0]    r_tag_x [NUM_CORES];
   logic [Y_BITS-1:0]    r_tag_y [NUM_CORES];
   logic [X_BITS-1:0]    r_core_x;
   logic [Y_BITS-1:0]    r_core_y;
   logic                 r_res_valid;
   logic [X_BITS-1:0]    r_res_x;
   logic [Y_BITS-1:0]    r_res_y;
   logic [ITER_BITS-1:0] r_res_iter;

   logic [PTR_W:0]       w_iss_pick;
   logic [PTR_W:0]       w_col_pick;
   logic [PTR_W-1:0]     w_iss_idx;
   logic [PTR_W-1:0]     w_col_idx;
   logic                 w_iss_en;
   logic                 w_col_en;
   logic                 w_iss_fire;
   logic                 w_col_fire;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_CLEAR;
         S_CLEAR: w_next = S_ISSUE;
         S_ISSUE: if (w_iss_fire && pix_last) w_next = S_DRAIN;
         S_DRAIN: if ((r_busy == '0) && (!r_res_valid || res_ready)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      pix_clear  = 1'b0;
      frame_done = 1'b0;
      w_iss_en   = 1'b0;
      w_col_en   = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_CLEAR: pix_clear  = 1'b1;
         S_ISSUE: w_iss_en   = 1'b1;
         S_DONE:  frame_done = 1'b1;
         default: ;
      endcase
      if (r_state != S_IDLE) w_col_en = !r_res_valid || res_ready;
   end

   // Freed cores only become issuable once r_busy drops on the next edge.
   assign w_iss_pick = f_pick(~r_busy, r_iptr);
   assign w_col_pick = f_pick(core_done & r_busy, r_cptr);
   assign w_iss_idx  = w_iss_pick[PTR_W-1:0];
   assign w_col_idx  = w_col_pick[PTR_W-1:0];
   assign w_iss_fire = w_iss_en && w_iss_pick[PTR_W];
   assign w_col_fire = w_col_en && w_col_pick[PTR_W];

   assign pix_step   = w_iss_fire;
   assign core_start = w_iss_fire ? (ONE_HOT0 << w_iss_idx) : '0;
   assign core_ack   = w_col_fire ? (ONE_HOT0 << w_col_idx) : '0;
   assign core_x     = w_iss_fire ? pix_x : r_core_x;
   assign core_y     = w_iss_fire ? pix_y : r_core_y;
   assign res_valid  = r_res_valid;
   assign res_x      = r_res_x;
   assign res_y      = r_res_y;
   assign res_iter   = r_res_iter;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy      <= '0;
         r_iptr      <= '0;
         r_cptr      <= '0;
         r_core_x    <= '0;
         r_core_y    <= '0;
         r_res_valid <= 1'b0;
         r_res_x     <= '0;
         r_res_y     <= '0;
         r_res_iter  <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            r_tag_x[i] <= '0;
            r_tag_y[i] <= '0;
         end
      end else begin
         r_busy <= (r_busy | core_start) & ~core_ack;
         if (w_iss_fire) begin
            r_tag_x[w_iss_idx] <= pix_x;
            r_tag_y[w_iss_idx] <= pix_y;
            r_core_x           <= pix_x;
            r_core_y           <= pix_y;
            r_iptr             <= f_wrap(w_iss_idx, 1);
         end
         if (w_col_fire) begin
            r_res_valid <= 1'b1;
            r_res_x     <= r_tag_x[w_col_idx];
            r_res_y     <= r_tag_y[w_col_idx];
            r_res_iter  <= core_iter[int'(w_col_idx)*ITER_BITS +: ITER_BITS];
            r_cptr      <= f_wrap(w_col_idx, 1);
         end else if (res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

`ifdef JULIA_PERF_CNT_EN
   logic [31:0] r_run_cnt;
   logic [31:0] r_frame_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run_cnt      <= '0;
         r_frame_cycles <= '0;
      end else begin
         case (r_state)
            S_CLEAR: r_run_cnt <= 32'd1;
            S_ISSUE, S_DRAIN: if (r_run_cnt != '1) r_run_cnt <= r_run_cnt + 32'd1;
            S_DONE:  r_frame_cycles <= (r_run_cnt == '1) ? '1 : r_run_cnt + 32'd1;
            default: ;
         endcase
      end
   end

   assign frame_cycles = r_frame_cycles;
`endif

endmodule

`default_nettype wire
